// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO. It holds the storage array and also has
// pointer control, occupancy count, status flags and overflow/underflow pulses.
//
// Ports:
//   clk, rst         clock (rising edge); asynchronous active-high reset
//   wr_en, wr_data   write request and data; dropped while full
//   rd_en            pop request; rejected while empty
//   rd_valid/rd_data popped word (registered mode) or head word (FWFT mode)
//   full, empty, almost_full, almost_empty, count   occupancy status
//   overflow/underflow   one-cycle pulse per write-while-full / read-while-empty
//
// Build option:
//   SYNC_FIFO_FWFT_EN  first-word-fall-through. rd_data shows the head entry
//                      combinationally, rd_valid = ~empty, and rd_en pops with
//                      zero latency. When it is undefined, reads are registered
//                      with a latency of one cycle.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH    = 8,
    parameter int FIFO_DEPTH    = 8,
    parameter int PTR_WIDTH     = 3,
    parameter int AFULL_THRESH  = 6,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic                  rd_valid,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [PTR_WIDTH:0]    count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [PTR_WIDTH:0] PTR_ONE    = {{PTR_WIDTH{1'b0}}, 1'b1};
    localparam logic [PTR_WIDTH:0] AFULL_LVL  = AFULL_THRESH[PTR_WIDTH:0];
    localparam logic [PTR_WIDTH:0] AEMPTY_LVL = AEMPTY_THRESH[PTR_WIDTH:0];

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];

    // Pointers carry one extra wrap bit. It tells full apart from empty when
    // the two addresses are equal.
    logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_WIDTH:0] count_q, count_d;
    logic               overflow_q, overflow_d;
    logic               underflow_q, underflow_d;

    logic [PTR_WIDTH-1:0] wr_addr, rd_addr;
    logic                 full_w, empty_w, wr_acc, rd_acc;

    assign wr_addr = wr_ptr_q[PTR_WIDTH-1:0];
    assign rd_addr = rd_ptr_q[PTR_WIDTH-1:0];
    assign full_w  = (wr_addr == rd_addr) && (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
    assign empty_w = (wr_ptr_q == rd_ptr_q);

    // Status comes only from registered state. When the FIFO is full a
    // simultaneous read still drains, and when it is empty a simultaneous
    // write still fills. No data passes from write to read in the same cycle.
    assign wr_acc = wr_en & ~full_w;
    assign rd_acc = rd_en & ~empty_w;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        overflow_d  = wr_en & full_w;
        underflow_d = rd_en & empty_w;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage has no reset. Entries are only ever read after they are written.
    always_ff @(posedge clk) begin
        if (wr_acc) mem_q[wr_addr] <= wr_data;
    end

`ifdef SYNC_FIFO_FWFT_EN
    assign rd_data  = mem_q[rd_addr];
    assign rd_valid = ~empty_w;
`else
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

    always_comb begin
        rd_valid_d = rd_acc;
        rd_data_d  = rd_acc ? mem_q[rd_addr] : rd_data_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
`endif

    assign full         = full_w;
    assign empty        = empty_w;
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_LVL);
    assign almost_empty = (count_q <= AEMPTY_LVL);
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule
